// File: rtl/basic_xor.sv
`timescale 1ps/100fs
// basic_xor: registered a^b cell model with setup, hold and reset-recovery checks.
// A timing violation makes the captured value unknown until the next clean capture or reset.
module basic_xor #(
   parameter int SETUP_PS    = 15,
   parameter int HOLD_PS     = 5,
   parameter int CLK_TO_Q_PS = 0
) (
   input  logic      a,
   input  logic      b,
   input  logic      clk,
   output logic      out,
   input  tri1 logic rst_n
);

   localparam longint NEVER = -64'sd1000000000;

   integer violation_count = 0;
   logic   q               = 1'b0;
   logic   q_x             = 1'b0;
   logic   armed           = 1'b0;
   logic   a_d             = 1'b0;
   logic   b_d             = 1'b0;
   logic   clk_d           = 1'b0;
   logic   rst_d           = 1'b1;
   longint t_a             = NEVER;
   longint t_b             = NEVER;
   longint t_rst           = NEVER;
   longint t_edge          = NEVER;

   function automatic longint now_ps();
      return longint'($time);
   endfunction

   function automatic logic hold_hit(input logic chg);
      return chg && armed && ((now_ps() - t_edge) < longint'(HOLD_PS));
   endfunction

   // The very first rising edge has no earlier reference, so checks arm after it.
   function automatic logic setup_hit(input logic chg, input longint t_last);
      return clk && !clk_d && armed &&
             (chg || ((now_ps() - t_last) < longint'(SETUP_PS)));
   endfunction

   function automatic logic [4:0] hits();
      return {hold_hit(a != a_d), hold_hit(b != b_d),
              setup_hit(a != a_d, t_a), setup_hit(b != b_d, t_b),
              setup_hit(!rst_d, t_rst)};
   endfunction

   task automatic report(input string sig, input string kind, input longint edge_t);
      $warning("%0t ps: %s %s violation, clk edge at %0t ps", now_ps(), sig, kind, edge_t);
   endtask

   always @(posedge a or negedge a or posedge b or negedge b or
            posedge clk or negedge clk or posedge rst_n or negedge rst_n) begin : timing_model
      a_d   <= a;
      b_d   <= b;
      clk_d <= clk;
      rst_d <= rst_n;
      if (a != a_d) t_a <= now_ps();
      if (b != b_d) t_b <= now_ps();
      if (rst_n && !rst_d) t_rst <= now_ps();

      if (!rst_n) begin
         q   <= 1'b0;
         q_x <= 1'b0;
      end else begin
         if (hold_hit(a != a_d)) report("a", "hold", t_edge);
         if (hold_hit(b != b_d)) report("b", "hold", t_edge);
         if (clk && !clk_d) begin
            if (setup_hit(a != a_d, t_a))  report("a", "setup", now_ps());
            if (setup_hit(b != b_d, t_b))  report("b", "setup", now_ps());
            if (setup_hit(!rst_d, t_rst)) report("rst_n", "recovery", now_ps());
            q      <= a ^ b;
            q_x    <= setup_hit(a != a_d, t_a) || setup_hit(b != b_d, t_b) ||
                      setup_hit(!rst_d, t_rst);
            armed  <= 1'b1;
            t_edge <= now_ps();
         end else if (|hits()) begin
            q_x <= 1'b1;
         end
         violation_count <= violation_count + $countones(hits());
      end
   end

   if (CLK_TO_Q_PS == 0) begin : g_no_delay
      assign out = q_x ? 1'bx : q;
   end else begin : g_delay
      assign #(CLK_TO_Q_PS) out = q_x ? 1'bx : q;
   end

endmodule

// File: tb/tb_basic_xor.sv
`timescale 1ps/100fs
// tb_basic_xor: directed timing scenarios for basic_xor with hand-derived expected values.
module tb_basic_xor;

   logic a     = 1'b0;
   logic b     = 1'b0;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic out;

   int errors = 0;
   int checks = 0;

   basic_xor dut (
      .a     (a),
      .b     (b),
      .clk   (clk),
      .out   (out),
      .rst_n (rst_n)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t ps: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic wait_to(input longint t);
      #(t - longint'($time));
   endtask

   task automatic chk_out(input string tag, input logic exp);
      check_eq({tag, "_out"}, {31'd0, out}, {31'd0, exp});
   endtask

   task automatic chk_x(input string tag, input logic exp);
      check_eq({tag, "_x"}, {31'd0, dut.q_x}, {31'd0, exp});
   endtask

   task automatic chk_vc(input string tag, input int exp);
      check_eq({tag, "_vc"}, dut.violation_count, exp);
   endtask

   // Clock: irregular edges so each scenario lands at a chosen distance from an edge.
   initial begin : clock_gen
      longint edges[$] = '{70, 90, 102, 112, 135, 150, 170, 185, 210, 225, 240, 255,
                           260, 270, 280, 290, 300, 310, 340, 355, 370, 380, 400, 410};
      foreach (edges[i]) begin
         wait_to(edges[i]);
         clk = ~clk;
      end
   end

   initial begin : stimulus
      wait_to(1);    chk_out("time0", 1'b0); chk_vc("time0", 0);
      wait_to(20);   a = 1'b1;
      wait_to(25);   chk_out("between_edges", 1'b0);
      wait_to(30);   a = 1'b0;
      wait_to(40);   b = 1'b1;
      wait_to(50);   b = 1'b0;
      wait_to(60);   a = 1'b1;
      wait_to(65);   chk_out("pre_first_edge", 1'b0);
      wait_to(71);   chk_out("first_edge", 1'b1); chk_x("first_edge", 1'b0); chk_vc("first_edge", 0);
      wait_to(80);   a = 1'b0;
      wait_to(85);   chk_out("hold_between", 1'b1);
      wait_to(91);   chk_out("fall_edge", 1'b1);
      wait_to(92);   b = 1'b1;
      wait_to(103);  chk_x("setup_b", 1'b1); chk_vc("setup_b", 1);
      wait_to(113);  chk_x("x_sticky", 1'b1);
      wait_to(115);  a = 1'b1;
      wait_to(136);  chk_out("recover", 1'b0); chk_x("recover", 1'b0); chk_vc("recover", 1);
      wait_to(138);  b = 1'b0;
      wait_to(139);  chk_x("hold_b", 1'b1); chk_vc("hold_b", 2);
      wait_to(171);  chk_out("clean_after_hold", 1'b1); chk_x("clean_after_hold", 1'b0);
                     chk_vc("clean_after_hold", 2);
      wait_to(195);  a = 1'b0;
      wait_to(211);  chk_out("setup_exact", 1'b0); chk_vc("setup_exact", 2);
      wait_to(215);  b = 1'b1;
      wait_to(216);  chk_out("hold_exact", 1'b0); chk_vc("hold_exact", 2);
      wait_to(241);  chk_out("after_exact", 1'b1); chk_vc("after_exact", 2);
      wait_to(250);  a = 1'b1; b = 1'b0;
      wait_to(261);  chk_x("setup_both", 1'b1); chk_vc("setup_both", 4);
      wait_to(275);  rst_n = 1'b0;
      wait_to(276);  chk_out("reset_from_x", 1'b0); chk_x("reset_from_x", 1'b0);
      wait_to(282);  a = 1'b0;
      wait_to(283);  b = 1'b1;
      wait_to(295);  a = 1'b1;
      wait_to(301);  chk_out("reset_held", 1'b0); chk_vc("reset_held", 4);
      wait_to(312);  b = 1'b0;
      wait_to(320);  rst_n = 1'b1;
      wait_to(321);  chk_out("release", 1'b0);
      wait_to(341);  chk_out("post_release", 1'b1); chk_vc("post_release", 4);
      wait_to(350);  rst_n = 1'b0;
      wait_to(351);  chk_out("reset_from_1", 1'b0);
      wait_to(365);  rst_n = 1'b1;
      wait_to(371);  chk_x("recovery", 1'b1); chk_vc("recovery", 5);
      wait_to(401);  chk_out("after_recovery", 1'b1); chk_x("after_recovery", 1'b0);
                     chk_vc("after_recovery", 5);
      wait_to(420);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
